// File: rtl/hex_ascii_uart_tx_if.sv
// Purpose: request/serial bundle between the multiplier core and the hex ASCII UART formatter.
// Latency: none, wiring only.
// Backpressure: the master may raise start at any time; only start while ready is high is taken.
interface hex_ascii_uart_tx_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] data_in;
    logic                    start;
    logic                    ready;
    logic                    done;
    logic                    tx;

    // Core side: offers a result and watches the handshake and the serial line.
    modport master (
        output data_in,
        output start,
        input  ready,
        input  done,
        input  tx
    );

    // Formatter side.
    modport slave (
        input  data_in,
        input  start,
        output ready,
        output done,
        output tx
    );
endinterface

// File: rtl/hex_ascii_uart_tx.sv
// Purpose: send a 4*NUM_DIGITS-bit result as NUM_DIGITS uppercase ASCII hex chars, MSN first, on 8N1 UART.
// Latency: start bit drives out at the acceptance edge; done pulses NUM_DIGITS*10*CLKS_PER_BIT cycles later.
// Backpressure: ready is low for the whole request; start seen while ready is low is dropped, not queued.
module hex_ascii_uart_tx #(
    parameter int CLKS_PER_BIT = 347,
    parameter int NUM_DIGITS   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    hex_ascii_uart_tx_if.slave   bus
);

    localparam int W      = 4 * NUM_DIGITS;
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int DIG_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START_BIT = 2'd1,
        DATA_BITS = 2'd2,
        STOP_BIT  = 2'd3
    } state_t;

    state_t              r_state;
    logic [BAUD_W-1:0]   r_baud;
    logic [2:0]          r_bit;
    logic [DIG_W-1:0]    r_digit;
    logic [W-1:0]        r_shift;
    logic [7:0]          r_byte;
    logic                r_tx;
    logic                r_ready;
    logic                r_done;

    logic                w_baud_last;
    logic                w_last_digit;
    logic [W-1:0]        w_shift_next;

    // Nibble to uppercase ASCII hex: '0'..'9' then 'A'..'F'.
    function automatic logic [7:0] f_ascii(input logic [3:0] n);
        logic [7:0] w_n;
        w_n = {4'h0, n};
        if (n < 4'd10) begin
            return 8'h30 + w_n;
        end
        return 8'h37 + w_n;
    endfunction

    // End of the current bit period and end of the whole result.
    always_comb begin
        w_baud_last  = (r_baud == BAUD_W'(CLKS_PER_BIT - 1));
        w_last_digit = (r_digit == DIG_W'(NUM_DIGITS - 1));
        w_shift_next = r_shift << 4;
    end

    // Single-process FSM: framing, counters and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_digit <= '0;
            r_shift <= '0;
            r_byte  <= '0;
            r_tx    <= 1'b1;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            // done is a single-cycle strobe unless the stop state sets it below.
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_tx    <= 1'b1;
                    r_ready <= 1'b1;
                    r_baud  <= '0;
                    r_bit   <= '0;
                    if (bus.start && r_ready) begin
                        // Capture the whole result now so later data_in changes cannot leak in.
                        r_shift <= bus.data_in;
                        r_byte  <= f_ascii(bus.data_in[W-1 -: 4]);
                        r_digit <= '0;
                        r_tx    <= 1'b0;
                        r_ready <= 1'b0;
                        r_state <= START_BIT;
                    end
                end

                START_BIT: begin
                    if (w_baud_last) begin
                        r_baud  <= '0;
                        r_bit   <= '0;
                        r_tx    <= r_byte[0];
                        r_state <= DATA_BITS;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end

                DATA_BITS: begin
                    if (w_baud_last) begin
                        r_baud <= '0;
                        if (r_bit == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= STOP_BIT;
                        end else begin
                            r_bit <= r_bit + 3'd1;
                            r_tx  <= r_byte[r_bit + 3'd1];
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end

                STOP_BIT: begin
                    if (w_baud_last) begin
                        r_baud <= '0;
                        if (!w_last_digit) begin
                            // Next character starts immediately, no idle gap.
                            r_digit <= r_digit + 1'b1;
                            r_shift <= w_shift_next;
                            r_byte  <= f_ascii(w_shift_next[W-1 -: 4]);
                            r_tx    <= 1'b0;
                            r_state <= START_BIT;
                        end else begin
                            r_done  <= 1'b1;
                            r_ready <= 1'b1;
                            r_state <= IDLE;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_tx    <= 1'b1;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.tx    = r_tx;
    assign bus.ready = r_ready;
    assign bus.done  = r_done;

endmodule

// File: tb/tb_hex_ascii_uart_tx.sv
// Purpose: directed scoreboard bench for hex_ascii_uart_tx; a UART receiver model checks every byte.
// Latency: request latency is measured from the acceptance edge to the done pulse.
// Backpressure: covers start ignored while busy and start held high across done.
module tb_hex_ascii_uart_tx;

    localparam int CPB   = 16;
    localparam int ND    = 4;
    localparam int FRAME = 10 * CPB;
    localparam int REQ   = ND * FRAME;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    hex_ascii_uart_tx_if #(.NUM_DIGITS(ND)) bus ();

    hex_ascii_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .NUM_DIGITS  (ND)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int         checks   = 0;
    int         errors   = 0;
    int         rx_count = 0;
    int         cyc_now  = 0;
    int         t_acc    = 0;
    logic [7:0] sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected characters come from a lookup table, MSN first.
    task automatic push_expect(input logic [15:0] v);
        string      hexc;
        logic [3:0] n;
        hexc = "0123456789ABCDEF";
        for (int i = 0; i < ND; i++) begin
            n = v[15 - 4*i -: 4];
            sb.push_back(8'(hexc[n]));
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc_now++;
    end

    // UART receiver: detect start bit, sample each bit at its middle, compare against scoreboard.
    initial begin : monitor
        bit         busy;
        int         c;
        int         k;
        logic [7:0] b;
        logic [7:0] exp_b;
        busy = 0;
        c    = 0;
        b    = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                busy = 0;
            end else if (!busy) begin
                if (bus.tx === 1'b0) begin
                    busy = 1;
                    c    = 0;
                end
            end else begin
                c++;
                if ((c % CPB) == (CPB / 2)) begin
                    k = c / CPB;
                    if (k == 0) begin
                        chk("rx_start_bit_low", bus.tx, 1'b0);
                    end else if (k <= 8) begin
                        b[k-1] = bus.tx;
                    end else begin
                        chk("rx_stop_bit_high", bus.tx, 1'b1);
                        rx_count++;
                        chk("rx_byte_expected", (sb.size() != 0), 1'b1);
                        if (sb.size() != 0) begin
                            exp_b = sb.pop_front();
                            chk("rx_byte_value", b, exp_b);
                        end
                        busy = 0;
                    end
                end
            end
        end
    end

    // Offer one request; optionally keep start high afterwards.
    task automatic send(input logic [15:0] v, input bit hold);
        @(negedge clk);
        chk("ready_before_start", bus.ready, 1'b1);
        bus.data_in = v;
        bus.start   = 1'b1;
        push_expect(v);
        @(posedge clk);
        #1;
        t_acc = cyc_now;
        chk("tx_low_at_accept", bus.tx, 1'b0);
        chk("ready_low_at_accept", bus.ready, 1'b0);
        chk("done_low_at_accept", bus.done, 1'b0);
        if (!hold) begin
            @(negedge clk);
            bus.start   = 1'b0;
            bus.data_in = ~v;
        end
    endtask

    // Wait (bounded) for done; check latency, ready rising with done, ready low while busy.
    task automatic wait_done(input string tag);
        bit seen;
        int bad_ready;
        seen      = 0;
        bad_ready = 0;
        while (!seen && (cyc_now - t_acc) < REQ + 200) begin
            @(posedge clk);
            #1;
            seen = (bus.done === 1'b1);
            if (!seen && bus.ready !== 1'b0) bad_ready++;
        end
        chk({tag, "_done_seen"}, seen, 1'b1);
        chk({tag, "_done_latency"}, cyc_now - t_acc, REQ);
        chk({tag, "_ready_with_done"}, bus.ready, 1'b1);
        chk({tag, "_ready_low_busy"}, bad_ready, 0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        int bad;
        bus.data_in = '0;
        bus.start   = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("reset_tx", bus.tx, 1'b1);
        chk("reset_ready", bus.ready, 1'b1);
        chk("reset_done", bus.done, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // Idle: line high, ready high, no done.
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (bus.tx !== 1'b1 || bus.ready !== 1'b1 || bus.done !== 1'b0) bad++;
        end
        chk("idle_1000_cycles", bad, 0);

        // Main pattern; data_in is inverted after acceptance inside send.
        send(16'h13F8, 1'b0);
        wait_done("r13F8");
        @(posedge clk);
        #1;
        chk("done_one_cycle", bus.done, 1'b0);

        // Boundary values.
        send(16'h0000, 1'b0);
        wait_done("r0000");
        send(16'hFFFF, 1'b0);
        wait_done("rFFFF");
        send(16'h9A09, 1'b0);
        wait_done("r9A09");

        // Start during the second character is ignored.
        send(16'hABCD, 1'b0);
        repeat (FRAME + 3*CPB) @(negedge clk);
        chk("ready_low_mid_frame", bus.ready, 1'b0);
        bus.data_in = 16'h1234;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start   = 1'b0;
        wait_done("rABCD");
        repeat (2*FRAME) @(negedge clk);
        chk("no_extra_frame", sb.size(), 0);

        // Reset in the data bits of the third character.
        send(16'hC0DE, 1'b0);
        repeat (2*FRAME + 4*CPB) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midreset_tx", bus.tx, 1'b1);
        chk("midreset_ready", bus.ready, 1'b1);
        chk("midreset_done", bus.done, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("midreset_two_chars_rx", sb.size(), 2);
        sb.delete();
        bad = 0;
        for (int i = 0; i < REQ; i++) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.tx !== 1'b1) bad++;
        end
        chk("midreset_quiet", bad, 0);
        send(16'h00FF, 1'b0);
        wait_done("r00FF");

        // Start held through done; new data presented as done fires.
        send(16'h5A5A, 1'b1);
        wait_done("r5A5A");
        chk("b2b_idle_cycle_tx", bus.tx, 1'b1);
        @(negedge clk);
        bus.data_in = 16'h0F0F;
        push_expect(16'h0F0F);
        @(posedge clk);
        #1;
        t_acc = cyc_now;
        chk("b2b_start_bit", bus.tx, 1'b0);
        chk("b2b_ready_low", bus.ready, 1'b0);
        chk("b2b_done_dropped", bus.done, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("r0F0F");

        repeat (2*FRAME) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        chk("bytes_received", rx_count, 34);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
